// File: rtl/session_guard.sv
// Session stage behind the authenticator: idle-timeout FSM with forced logout,
// plus a 32-entry best-score table for registered (non-guest) players.
module session_guard #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int IDLE_SECONDS = 30,
  parameter int WARN_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LoggedIn,
  input  logic       isGuest_from_Auth,
  input  logic [4:0] PlayerAddress_from_Auth,
  input  logic       ActivityPulse,
  input  logic       GameOver,
  input  logic [7:0] Score,
  output logic       LogoutCommand_to_Auth,
  output logic       SessionActive,
  output logic       TimeoutWarning,
  output logic [7:0] BestScore,
  output logic       NewRecord
);

  localparam int TickW = $clog2(TICK_DIV);
  localparam int SecW  = $clog2(IDLE_SECONDS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [SecW-1:0]  WarnAt   = SecW'(IDLE_SECONDS - WARN_SECONDS);
  localparam logic [SecW-1:0]  LogoutAt = SecW'(IDLE_SECONDS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StWarn   = 2'd2;
  localparam logic [1:0] StLogout = 2'd3;

  logic [1:0]       state, stateNext;
  logic [TickW-1:0] tickCount, tickNext;
  logic [SecW-1:0]  idleSec, idleNext, idleInc;
  logic [4:0]       addrReg;
  logic             guestReg;
  logic             logoutFired;
  logic [7:0]       scoreTable [32];
  logic [7:0]       curBest;
  logic             inSession;
  logic             activity;
  logic             recordHit;

  assign inSession = (state == StActive) || (state == StWarn);
  assign activity  = inSession && (ActivityPulse || GameOver);
  assign idleInc   = idleSec + SecW'(1);
  assign curBest   = scoreTable[addrReg];
  assign recordHit = inSession && GameOver && !guestReg && (Score > curBest);

  always_comb begin
    stateNext = state;
    tickNext  = tickCount;
    idleNext  = idleSec;
    case (state)
      StIdle: begin
        if (LoggedIn) begin
          stateNext = StActive;
          tickNext  = '0;
          idleNext  = '0;
        end
      end
      StActive, StWarn: begin
        if (!LoggedIn) begin
          stateNext = StIdle;
          tickNext  = '0;
          idleNext  = '0;
        end else if (activity) begin
          // Activity outranks a threshold crossing in the same cycle.
          stateNext = StActive;
          tickNext  = '0;
          idleNext  = '0;
        end else if (tickCount == TickLast) begin
          tickNext = '0;
          idleNext = idleInc;
          if (state == StActive && idleInc == WarnAt) stateNext = StWarn;
          if (state == StWarn && idleInc == LogoutAt) stateNext = StLogout;
        end else begin
          tickNext = tickCount + TickW'(1);
        end
      end
      StLogout: begin
        if (!LoggedIn) stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      tickCount <= '0;
      idleSec   <= '0;
      addrReg   <= '0;
      guestReg  <= 1'b0;
    end else begin
      state     <= stateNext;
      tickCount <= tickNext;
      idleSec   <= idleNext;
      if (state == StIdle && LoggedIn) begin
        addrReg  <= PlayerAddress_from_Auth;
        guestReg <= isGuest_from_Auth;
      end
    end
  end

  // Table lives in flops so that reset can clear every entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) scoreTable[i] <= '0;
    end else if (recordHit) begin
      scoreTable[addrReg] <= Score;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SessionActive         <= 1'b0;
      TimeoutWarning        <= 1'b0;
      LogoutCommand_to_Auth <= 1'b0;
      logoutFired           <= 1'b0;
      NewRecord             <= 1'b0;
      BestScore             <= '0;
    end else begin
      SessionActive         <= inSession;
      TimeoutWarning        <= (state == StWarn);
      LogoutCommand_to_Auth <= (state == StLogout) && !logoutFired;
      logoutFired           <= (state == StLogout);
      NewRecord             <= recordHit;
      if (!inSession || guestReg) BestScore <= '0;
      else if (recordHit)         BestScore <= Score;
      else                        BestScore <= curBest;
    end
  end

endmodule
